// File: rtl/mmio_req_pkg.sv
// Shared types and constants for the MMIO requester: FSM state encoding,
// MMIO bus widths and the well-known AFU register addresses.
package mmio_req_pkg;

  localparam int MMIO_ADDR_W = 16;
  localparam int MMIO_TID_W  = 9;
  localparam int MMIO_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Device feature header registers (32-bit word addresses)
  localparam logic [MMIO_ADDR_W-1:0] DFH_ADDR      = 16'h0000;
  localparam logic [MMIO_ADDR_W-1:0] DFH_ID_L_ADDR = 16'h0002;
  localparam logic [MMIO_ADDR_W-1:0] DFH_ID_H_ADDR = 16'h0004;
  localparam logic [MMIO_ADDR_W-1:0] DFH_NEXT_ADDR = 16'h0006;
  localparam logic [MMIO_ADDR_W-1:0] DFH_RSVD_ADDR = 16'h0008;
  // First user register
  localparam logic [MMIO_ADDR_W-1:0] USER_REG_ADDR = 16'h0020;

  // 64-bit accesses must start on an even 32-bit word address
  function automatic logic addr_misaligned(input logic [MMIO_ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mmio_requester.sv
// Single-outstanding MMIO requester: turns local commands into one-cycle
// MMIO read/write strobes toward the AFU, matches read responses by TID,
// and returns one completion per command (posted writes, misaligned and
// timed-out reads complete with zero data; the latter two flag an error).
module mmio_requester
  import mmio_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_wr,
  input  logic [MMIO_ADDR_W-1:0] cmd_addr,
  input  logic [MMIO_DATA_W-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [MMIO_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   mmio_wr_valid,
  output logic                   mmio_rd_valid,
  output logic [MMIO_ADDR_W-1:0] mmio_addr,
  output logic [MMIO_TID_W-1:0]  mmio_tid,
  output logic [MMIO_DATA_W-1:0] mmio_wdata,
  input  logic                   mmio_rsp_valid,
  input  logic [MMIO_TID_W-1:0]  mmio_rsp_tid,
  input  logic [MMIO_DATA_W-1:0] mmio_rsp_data
);

  localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  state_e                  state_r;
  logic                    wr_r;        // latched command direction
  logic [MMIO_TID_W-1:0]   tag_r;       // next read TID
  logic [WAIT_W-1:0]       wait_cnt_r;  // cycles spent in WAIT_RSP
  logic                    cmd_ready_r;
  logic                    rsp_valid_r;
  logic                    rsp_err_r;
  logic [MMIO_DATA_W-1:0]  rsp_rdata_r;
  logic                    mmio_wr_valid_r;
  logic                    mmio_rd_valid_r;
  logic [MMIO_ADDR_W-1:0]  mmio_addr_r;
  logic [MMIO_TID_W-1:0]   mmio_tid_r;
  logic [MMIO_DATA_W-1:0]  mmio_wdata_r;
  logic                    rsp_match_s;

  // A response only counts when it carries the TID of the read in flight
  assign rsp_match_s = mmio_rsp_valid && (mmio_rsp_tid == mmio_tid_r);

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_err       = rsp_err_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign mmio_wr_valid = mmio_wr_valid_r;
  assign mmio_rd_valid = mmio_rd_valid_r;
  assign mmio_addr     = mmio_addr_r;
  assign mmio_tid      = mmio_tid_r;
  assign mmio_wdata    = mmio_wdata_r;

  // Transaction FSM with tag and wait counters; every output is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      wr_r            <= 1'b0;
      tag_r           <= '0;
      wait_cnt_r      <= '0;
      cmd_ready_r     <= 1'b1;
      rsp_valid_r     <= 1'b0;
      rsp_err_r       <= 1'b0;
      rsp_rdata_r     <= '0;
      mmio_wr_valid_r <= 1'b0;
      mmio_rd_valid_r <= 1'b0;
      mmio_addr_r     <= '0;
      mmio_tid_r      <= '0;
      mmio_wdata_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            cmd_ready_r <= 1'b0;
            if (addr_misaligned(cmd_addr)) begin
              // Reject without touching the MMIO bus
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
            end else begin
              state_r         <= ISSUE;
              wr_r            <= cmd_wr;
              mmio_addr_r     <= cmd_addr;
              mmio_wdata_r    <= cmd_wdata;
              mmio_wr_valid_r <= cmd_wr;
              mmio_rd_valid_r <= !cmd_wr;
              if (!cmd_wr) begin
                mmio_tid_r <= tag_r;
              end
            end
          end
        end
        ISSUE: begin
          mmio_wr_valid_r <= 1'b0;
          mmio_rd_valid_r <= 1'b0;
          if (wr_r) begin
            // Posted write: complete right after the strobe
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
          end else begin
            state_r    <= WAIT_RSP;
            tag_r      <= tag_r + 9'd1;
            wait_cnt_r <= '0;
          end
        end
        WAIT_RSP: begin
          if (rsp_match_s) begin
            // A match on the last wait cycle still wins over the timeout
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= mmio_rsp_data;
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b1;
            rsp_rdata_r <= '0;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r         <= IDLE;
          cmd_ready_r     <= 1'b1;
          rsp_valid_r     <= 1'b0;
          mmio_wr_valid_r <= 1'b0;
          mmio_rd_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_requester.sv
// Randomized self-checking bench for mmio_requester. The bench plays both
// the command source and the AFU, and predicts every completion from the
// transaction rules: strobe one cycle after accept, posted write completes
// the cycle after, a read completes the cycle after its matching reply if
// that reply lands within the wait window, otherwise after the window.
module tb_mmio_requester;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [15:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;
  logic        mmio_wr_valid, mmio_rd_valid;
  logic [15:0] mmio_addr;
  logic [8:0]  mmio_tid;
  logic [63:0] mmio_wdata;
  logic        mmio_rsp_valid;
  logic [8:0]  mmio_rsp_tid;
  logic [63:0] mmio_rsp_data;

  int n_vec = 0;
  int n_err = 0;
  int exp_tid = 0;   // reference tag: count of issued reads modulo 512

  always #5 clk = ~clk;

  mmio_requester #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid),
    .mmio_rsp_data(mmio_rsp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_wr_valid"}, 64'(mmio_wr_valid), 64'd0);
    check({tag, "_rd_valid"}, 64'(mmio_rd_valid), 64'd0);
  endtask

  // One full command. Called at a negedge with the DUT idle; returns at a
  // negedge with the DUT idle again. match_c/wrong_c are the WAIT_RSP cycle
  // numbers (1 = first wait cycle) of the correct and wrong-TID replies;
  // a match_c outside 1..TO means the AFU never answers.
  task automatic run_cmd(input logic wr, input logic [15:0] addr, input logic [63:0] wdata,
                         input int match_c, input int wrong_c, input bit stray,
                         input logic [63:0] rdata, input int hold);
    logic [63:0] exp_data;
    logic        exp_err;
    logic [8:0]  tid;
    int          done;
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge clk);
    // Scramble the command bus: the transaction must use the latched copy
    cmd_valid = 1'b0; cmd_wr = 1'($urandom); cmd_addr = 16'($urandom);
    cmd_wdata = {$urandom, $urandom};
    check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
    if (addr[0]) begin
      check("misal_wr_strobe", 64'(mmio_wr_valid), 64'd0);
      check("misal_rd_strobe", 64'(mmio_rd_valid), 64'd0);
      exp_err = 1'b1; exp_data = 64'd0;
    end else begin
      check("wr_strobe", 64'(mmio_wr_valid), 64'(wr));
      check("rd_strobe", 64'(mmio_rd_valid), 64'(!wr));
      check("mmio_addr", 64'(mmio_addr), 64'(addr));
      if (wr) begin
        check("mmio_wdata", mmio_wdata, wdata);
        @(negedge clk);
        check("wr_strobe_off", 64'(mmio_wr_valid), 64'd0);
        exp_err = 1'b0; exp_data = 64'd0;
      end else begin
        tid = 9'(exp_tid);
        check("mmio_tid", 64'(mmio_tid), 64'(tid));
        exp_tid = (exp_tid + 1) % 512;
        if (match_c >= 1 && match_c <= TO) begin
          done = match_c + 1; exp_err = 1'b0; exp_data = rdata;
        end else begin
          done = TO + 1; exp_err = 1'b1; exp_data = 64'd0;
        end
        // A matching-TID reply during the strobe cycle is too early
        mmio_rsp_valid = stray; mmio_rsp_tid = tid; mmio_rsp_data = {$urandom, $urandom};
        for (int c = 1; c <= TO + 1; c++) begin
          @(negedge clk);
          check("rsp_valid_timing", 64'(rsp_valid), 64'(c == done));
          if (c == 1) check("rd_strobe_off", 64'(mmio_rd_valid), 64'd0);
          if (c == done) break;
          if (c == match_c) begin
            mmio_rsp_valid = 1'b1; mmio_rsp_tid = tid; mmio_rsp_data = rdata;
          end else if (c == wrong_c) begin
            mmio_rsp_valid = 1'b1; mmio_rsp_tid = tid ^ 9'($urandom_range(1, 511));
            mmio_rsp_data = {$urandom, $urandom};
          end else begin
            mmio_rsp_valid = 1'b0; mmio_rsp_tid = 9'($urandom); mmio_rsp_data = {$urandom, $urandom};
          end
        end
        mmio_rsp_valid = 1'b0;
      end
    end
    check("rsp_valid", 64'(rsp_valid), 64'd1);
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("rsp_rdata", rsp_rdata, exp_data);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      check("hold_rsp_err", 64'(rsp_err), 64'(exp_err));
      check("hold_rsp_rdata", rsp_rdata, exp_data);
      check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_idle_outputs("post_hs");
  endtask

  task automatic check_reset_values(input string tag);
    check_idle_outputs(tag);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_mmio_addr"}, 64'(mmio_addr), 64'd0);
    check({tag, "_mmio_tid"}, 64'(mmio_tid), 64'd0);
    check({tag, "_mmio_wdata"}, mmio_wdata, 64'd0);
  endtask

  initial begin
    logic        wr;
    logic [15:0] addr;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 16'd0; cmd_wdata = 64'd0;
    rsp_ready = 1'b0; mmio_rsp_valid = 1'b0; mmio_rsp_tid = 9'd0; mmio_rsp_data = 64'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_cmd(1'b1, 16'h0020, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b0, 64'd0, 0);
    run_cmd(1'b0, 16'h0000, 64'd0, 2, 0, 1'b0, 64'h1000_0100_0000_0000, 0);
    run_cmd(1'b0, 16'h0002, 64'd0, 4, 2, 1'b0, 64'h0000_0000_0000_00AA, 1);
    run_cmd(1'b0, 16'h0004, 64'd0, 0, 5, 1'b1, 64'd0, 0);
    run_cmd(1'b0, 16'h0006, 64'd0, TO, 3, 1'b0, 64'hCAFE_F00D_0000_0016, 0);
    run_cmd(1'b0, 16'h0003, 64'd0, 1, 0, 1'b0, 64'd0, 5);
    run_cmd(1'b1, 16'h0021, 64'hFFFF_0000_FFFF_0000, 0, 0, 1'b0, 64'd0, 2);

    // Randomized commands
    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom);
      addr = 16'($urandom);
      if ($urandom_range(0, 3) != 0) addr[0] = 1'b0;
      run_cmd(wr, addr, {$urandom, $urandom}, $urandom_range(1, TO + 2),
              $urandom_range(1, TO), 1'($urandom), {$urandom, $urandom},
              $urandom_range(0, 3));
    end

    // Back-to-back reads across the full tag space and its wrap
    for (int i = 0; i < 513; i++) begin
      addr = 16'($urandom);
      addr[0] = 1'b0;
      run_cmd(1'b0, addr, 64'd0, 1, 0, 1'b0, {$urandom, $urandom}, 0);
    end

    // Reset pulse while a read is waiting for its response
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0008; cmd_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_tid = 0;
    mmio_rsp_valid = 1'b1; mmio_rsp_tid = 9'(511); mmio_rsp_data = 64'h5555_AAAA_5555_AAAA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mmio_rsp_valid = 1'b0;
      check_reset_values("late_reply");
    end
    run_cmd(1'b0, 16'h0000, 64'd0, 3, 1, 1'b0, 64'h0123_4567_89AB_CDEF, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
